fetch: RTL and testbench
========================

# fetch

Instruction fetch stage of the cpu, sitting directly upstream of the decode unit. Owns the program counter, issues single-outstanding word reads to instruction memory, and holds fetched 16-bit instructions in a small buffer until decode takes them. Also handles control-flow redirects from the control logic by flushing buffered and in-flight instructions.

## Interface
- PC_WIDTH, 16: width of the word-addressed program counter.
- RESET_PC, 0: first fetch address after reset.

- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- fetch_en  in  1  allow new memory requests; when low, no new request starts, and an outstanding request still completes.
- branch_en  in  1  redirect fetch to branch_addr this cycle.
- branch_addr  in  PC_WIDTH  redirect target.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  PC_WIDTH  word address; stable while mem_req is high.
- mem_ack  in  1  request done; mem_data is valid in the same cycle.
- mem_data  in  16  instruction word returned by memory.
- inst  out  16  head instruction, presented to decode.
- inst_pc  out  PC_WIDTH  address of inst.
- inst_valid  out  1  inst/inst_pc are meaningful.
- inst_consume  in  1  decode takes the head instruction; this is decode's decode_en.

## Operation
- FSM states: IDLE (no request outstanding), REQ (mem_req high, waiting on ack), DISCARD (request outstanding whose data must be dropped).
- IDLE→REQ: fetch_en high, no branch_en, and the buffer is not full, counting an entry being consumed this cycle. On this transition mem_addr is loaded from the fetch PC.
- REQ→IDLE on mem_ack:
  - mem_data and mem_addr are pushed into the buffer.
  - The fetch PC is incremented by 1. It wraps from all-ones to 0.
- REQ with branch_en and no mem_ack:
  - Go to DISCARD.
  - mem_req and mem_addr are held; the request is never aborted.
- DISCARD→IDLE on mem_ack; the returned data is dropped.
- branch_en in any state:
  - Buffer is flushed.
  - Fetch PC is set to branch_addr.
  - If mem_ack arrives in the same cycle, that data is dropped and the FSM goes to IDLE.
- The buffer pops when inst_consume and inst_valid are both high. inst_consume while inst_valid is low is ignored.
- Simultaneous push and pop is legal at any occupancy, including full.
- branch_en together with inst_consume: the branch wins, and the buffer is empty after the edge.
- A second branch_en while in DISCARD stays in DISCARD and overwrites the target.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC.
  - inst=0, inst_pc=0, inst_valid=0.
  - FSM=IDLE, buffer empty, fetch PC=RESET_PC.
- All outputs are registered.
- If fetch_en is high at the first edge after rst_n rises, mem_req is high after that edge.
- A request may be acked at the earliest one cycle after mem_req rises, i.e. in the first cycle mem_req is seen high. Acks arriving while mem_req is low are ignored.
- Load-to-use: ack at edge N gives inst_valid=1 after edge N when the buffer was empty.
- Redirect latency from IDLE, with a one-cycle memory:
  - branch_en at edge N.
  - mem_req for branch_addr after N+1.
  - inst_valid after N+2.
- rst_n low mid-request forces the reset values at the next edge. The memory side must tolerate the dropped request.

## Configuration
- FETCH_PREFETCH_EN defined:
  - Buffer depth is 2.
  - A new request may issue while one instruction waits in the buffer.
  - Sustained throughput is one instruction per cycle with a 1-cycle memory.
- FETCH_PREFETCH_EN undefined:
  - Buffer depth is 1.
  - A request issues only when the buffer is empty, or is being consumed in the same cycle.

## Structure
- Shared package vgacpu_pkg holds:
  - the PC width constant,
  - the instruction width (16),
  - fetch_state_t enum {IDLE, REQ, DISCARD}.
- Sub-module fetch_buffer: a parameterised-depth FIFO of {inst, pc} with push, pop, flush, full, empty.

## Test plan
- Reset, fetch_en=1, memory acks 1 cycle after req with data = address+16'h1000 → inst_pc sequence 0,1,2 with inst 16'h1000,16'h1001,16'h1002; one instruction per cycle with FETCH_PREFETCH_EN.
- inst_consume held low → at most 2 buffered (1 without the macro); mem_req stays low after the buffer fills; raising inst_consume resumes fetching with no loss or duplication.
- branch_en to 16'h0040 while REQ at 16'h0005 is pending with ack delayed 3 cycles → the 16'h0005 data is dropped, the next request is 16'h0040, and the first valid inst_pc is 16'h0040.
- branch_en in the same cycle as mem_ack and inst_consume → buffer empty, ack data dropped, next mem_addr = branch_addr.
- Branch to 16'hFFFF with PC_WIDTH=16 → inst_pc 16'hFFFF followed by 16'h0000.
- rst_n low for 1 cycle mid-request → mem_req=0, inst_valid=0, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/vgacpu_pkg.sv
// Shared CPU definitions used by the fetch stage: PC and instruction widths,
// the fetch FSM state encoding and the instruction buffer depth.
// Build option: FETCH_PREFETCH_EN selects a two-entry buffer so a new request
// can overlap an instruction waiting for decode (one instruction per cycle
// with a single-cycle memory). Without it the buffer holds one instruction.
package vgacpu_pkg;

   localparam int PC_W   = 16;
   localparam int INST_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DISCARD
   } fetch_state_t;

`ifdef FETCH_PREFETCH_EN
   localparam int FETCH_BUF_DEPTH = 2;
`else
   localparam int FETCH_BUF_DEPTH = 1;
`endif

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-facing head
// instruction. The master side is the fetch stage; the slave side groups the
// memory and decode unit.
interface fetch_if import vgacpu_pkg::*; #(
   parameter int PC_WIDTH = PC_W
) ();

   logic                mem_req;
   logic [PC_WIDTH-1:0] mem_addr;
   logic                mem_ack;
   logic [INST_W-1:0]   mem_data;
   logic [INST_W-1:0]   inst;
   logic [PC_WIDTH-1:0] inst_pc;
   logic                inst_valid;
   logic                inst_consume;

   modport master (
      output mem_req, mem_addr, inst, inst_pc, inst_valid,
      input  mem_ack, mem_data, inst_consume
   );

   modport slave (
      input  mem_req, mem_addr, inst, inst_pc, inst_valid,
      output mem_ack, mem_data, inst_consume
   );

endinterface

// File: rtl/fetch_buffer.sv
// Shift-style FIFO of {instruction, pc}. Entry 0 is always the head, so the
// decode-facing outputs come straight from flops. Pop and push may happen in
// the same cycle at any occupancy; flush empties the buffer and wins over both.
module fetch_buffer #(
   parameter int DEPTH    = 1,
   parameter int DATA_W   = 16,
   parameter int PC_WIDTH = 16,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic [DATA_W-1:0]   push_inst,
   input  logic [PC_WIDTH-1:0] push_pc,
   input  logic                pop,
   input  logic                flush,
   output logic [DATA_W-1:0]   head_inst,
   output logic [PC_WIDTH-1:0] head_pc,
   output logic                head_valid,
   output logic                full,
   output logic                empty,
   output logic [CNT_W-1:0]    count
);

   logic [DEPTH-1:0]    valid_q, valid_d;
   logic [DATA_W-1:0]   inst_q [DEPTH];
   logic [DATA_W-1:0]   inst_d [DEPTH];
   logic [PC_WIDTH-1:0] pc_q   [DEPTH];
   logic [PC_WIDTH-1:0] pc_d   [DEPTH];
   logic                do_pop;
   logic                slot_taken;

   // Next buffer contents: shift out the head on pop, then drop the pushed
   // entry into the first free slot, then apply flush.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned and no latch is inferred.
      valid_d    = valid_q;
      inst_d     = inst_q;
      pc_d       = pc_q;
      do_pop     = pop && valid_q[0];
      slot_taken = 1'b0;

      if (do_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            valid_d[i] = valid_q[i + 1];
            inst_d[i]  = inst_q[i + 1];
            pc_d[i]    = pc_q[i + 1];
         end
         valid_d[DEPTH - 1] = 1'b0;
      end

      if (push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!valid_d[i] && !slot_taken) begin
               valid_d[i] = 1'b1;
               inst_d[i]  = push_inst;
               pc_d[i]    = push_pc;
               slot_taken = 1'b1;
            end
         end
      end

      if (flush) begin
         valid_d = '0;
      end
   end

   // Occupancy, used by the fetch FSM to decide whether a request fits.
   always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count = count + CNT_W'(valid_q[i]);
      end
   end

   // Buffer storage registers.
   always_ff @(posedge clk) begin
      // NOTE: the payload is reset as well as the valid bits because the head
      // entry drives inst/inst_pc directly and those must read zero after reset.
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         // NOTE: state is updated with non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
      end
   end

   assign head_inst  = inst_q[0];
   assign head_pc    = pc_q[0];
   assign head_valid = valid_q[0];
   assign full       = valid_q[DEPTH - 1];
   assign empty      = !valid_q[0];

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage. Owns the fetch PC, issues one outstanding word
// read at a time and buffers returned instructions for decode. A branch
// flushes the buffer and retargets the PC; a read already in flight is never
// aborted, its data is dropped on return instead.
// Build option: FETCH_PREFETCH_EN (see vgacpu_pkg) deepens the buffer to two
// entries so requests can run back to back.
module fetch import vgacpu_pkg::*; #(
   parameter int                  PC_WIDTH = PC_W,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fetch_en,
   input  logic                branch_en,
   input  logic [PC_WIDTH-1:0] branch_addr,
   fetch_if.master             bus
);

   localparam int CNT_W = $clog2(FETCH_BUF_DEPTH + 1);

   fetch_state_t        state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                mem_req_q, mem_req_d;
   logic [PC_WIDTH-1:0] mem_addr_q, mem_addr_d;

   logic                ack;
   logic                pop;
   logic                push;
   logic                room_idle;
   logic                room_push;
   logic [PC_WIDTH-1:0] pc_inc;

   logic                buf_full;
   logic                buf_empty;
   logic [CNT_W-1:0]    buf_count;
   logic [INST_W-1:0]   buf_inst;
   logic [PC_WIDTH-1:0] buf_pc;
   logic                buf_valid;

   // Handshake qualifiers and buffer-space checks for the FSM.
   always_comb begin
      // An ack only counts while a request is actually outstanding.
      ack       = bus.mem_ack && mem_req_q;
      pop       = bus.inst_consume && !buf_empty;
      pc_inc    = pc_q + PC_WIDTH'(1);
      // From IDLE nothing is pushed this cycle; a consume frees the slot.
      room_idle = !buf_full || pop;
      // Chaining straight into the next request must leave a slot for it
      // after this cycle's push and pop.
      room_push = (int'(buf_count) + 1 - int'(pop)) < FETCH_BUF_DEPTH;
   end

   // Fetch FSM next-state, PC and request-port update.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      push       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (branch_en) begin
               pc_d = branch_addr;
            end else if (fetch_en && room_idle) begin
               state_d    = REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = pc_q;
            end
         end

         REQ: begin
            if (branch_en) begin
               pc_d = branch_addr;
               if (ack) begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
               end else begin
                  state_d = DISCARD;
               end
            end else if (ack) begin
               push = 1'b1;
               pc_d = pc_inc;
               if (fetch_en && room_push) begin
                  mem_addr_d = pc_inc;
               end else begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
               end
            end
         end

         DISCARD: begin
            if (branch_en) begin
               pc_d = branch_addr;
            end
            if (ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // FSM, PC and memory request registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   fetch_buffer #(
      .DEPTH    (FETCH_BUF_DEPTH),
      .DATA_W   (INST_W),
      .PC_WIDTH (PC_WIDTH)
   ) u_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_inst  (bus.mem_data),
      .push_pc    (mem_addr_q),
      .pop        (pop),
      .flush      (branch_en),
      .head_inst  (buf_inst),
      .head_pc    (buf_pc),
      .head_valid (buf_valid),
      .full       (buf_full),
      .empty      (buf_empty),
      .count      (buf_count)
   );

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.inst       = buf_inst;
   assign bus.inst_pc    = buf_pc;
   assign bus.inst_valid = buf_valid;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage. A small memory responder acks each
// request after mem_delay extra cycles with data = address + 16'h1000.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fetch;
   import vgacpu_pkg::*;

   localparam int PCW   = 16;
   localparam int DEPTH = FETCH_BUF_DEPTH;
   localparam int STEP  = (DEPTH > 1) ? 1 : 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           fetch_en;
   logic           branch_en;
   logic [PCW-1:0] branch_addr;

   int checks = 0;
   int errors = 0;
   int mem_delay = 0;
   int wait_cnt = 0;

   fetch_if #(.PC_WIDTH(PCW)) bus ();

   fetch #(.PC_WIDTH(PCW), .RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_en    (fetch_en),
      .branch_en   (branch_en),
      .branch_addr (branch_addr),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // Memory responder: decides the ack for each cycle just after the edge.
   initial begin
      bus.mem_ack  = 1'b0;
      bus.mem_data = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_req === 1'b1) begin
            if (wait_cnt >= mem_delay) begin
               bus.mem_ack  = 1'b1;
               bus.mem_data = bus.mem_addr + 16'h1000;
               wait_cnt     = 0;
            end else begin
               bus.mem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
         end
      end
   end

   // Holds reset for two edges; returns at a falling edge with rst_n still low.
   task automatic apply_reset();
      @(negedge clk);
      rst_n            = 1'b0;
      fetch_en         = 1'b0;
      branch_en        = 1'b0;
      branch_addr      = '0;
      bus.inst_consume = 1'b0;
      mem_delay        = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0h want=0", bus.mem_req); end
      checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got=%0h want=0", bus.mem_addr); end
      checks++; if (bus.inst !== 16'h0000) begin errors++; $display("FAIL reset_inst got=%0h want=0", bus.inst); end
      checks++; if (bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL reset_inst_pc got=%0h want=0", bus.inst_pc); end
      checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got=%0h want=0", bus.inst_valid); end
   endtask

   task automatic test_stream();
      logic [15:0] rec_pc [3];
      logic [15:0] rec_inst [3];
      int          rec_s [3];
      int          n = 0;
      for (int k = 0; k < 3; k++) begin
         rec_pc[k] = 'x; rec_inst[k] = 'x; rec_s[k] = -1;
      end
      apply_reset();
      rst_n            = 1'b1;
      fetch_en         = 1'b1;
      bus.inst_consume = 1'b1;
      for (int s = 1; s <= 8; s++) begin
         @(negedge clk);
         if (s == 1) begin
            checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL stream_first_req got=%0h want=1", bus.mem_req); end
            checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL stream_first_addr got=%0h want=0", bus.mem_addr); end
         end
         if (bus.inst_valid === 1'b1 && n < 3) begin
            rec_pc[n] = bus.inst_pc; rec_inst[n] = bus.inst; rec_s[n] = s; n++;
         end
      end
      checks++; if (n != 3) begin errors++; $display("FAIL stream_count got=%0d want=3", n); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (rec_pc[k] !== 16'(k)) begin errors++; $display("FAIL stream_pc%0d got=%0h want=%0h", k, rec_pc[k], k); end
         checks++; if (rec_inst[k] !== 16'h1000 + 16'(k)) begin errors++; $display("FAIL stream_inst%0d got=%0h want=%0h", k, rec_inst[k], 16'h1000 + 16'(k)); end
         checks++; if (rec_s[k] != 2 + k * STEP) begin errors++; $display("FAIL stream_cycle%0d got=%0d want=%0d", k, rec_s[k], 2 + k * STEP); end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] rec_pc [4];
      logic [15:0] rec_inst [4];
      int          n = 0;
      int          req_cycles = 0;
      for (int k = 0; k < 4; k++) begin
         rec_pc[k] = 'x; rec_inst[k] = 'x;
      end
      apply_reset();
      rst_n    = 1'b1;
      fetch_en = 1'b1;
      for (int s = 1; s <= 10; s++) begin
         @(negedge clk);
         if (bus.mem_req === 1'b1) req_cycles++;
      end
      checks++; if (req_cycles != DEPTH) begin errors++; $display("FAIL bp_requests got=%0d want=%0d", req_cycles, DEPTH); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low got=%0h want=0", bus.mem_req); end
      checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%0h want=1", bus.inst_valid); end
      checks++; if (bus.inst_pc !== 16'h0000) begin errors++; $display("FAIL bp_head_pc got=%0h want=0", bus.inst_pc); end
      bus.inst_consume = 1'b1;
      for (int s = 0; s < 12; s++) begin
         if (bus.inst_valid === 1'b1 && n < 4) begin
            rec_pc[n] = bus.inst_pc; rec_inst[n] = bus.inst; n++;
         end
         @(negedge clk);
      end
      checks++; if (n != 4) begin errors++; $display("FAIL bp_resume_count got=%0d want=4", n); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (rec_pc[k] !== 16'(k)) begin errors++; $display("FAIL bp_resume_pc%0d got=%0h want=%0h", k, rec_pc[k], k); end
         checks++; if (rec_inst[k] !== 16'h1000 + 16'(k)) begin errors++; $display("FAIL bp_resume_inst%0d got=%0h want=%0h", k, rec_inst[k], 16'h1000 + 16'(k)); end
      end
   endtask

   task automatic test_branch_discard();
      logic        seen_low = 1'b0;
      logic        got_addr = 1'b0;
      logic        got_valid = 1'b0;
      logic [15:0] next_addr = 'x;
      logic [15:0] first_pc = 'x;
      logic [15:0] first_inst = 'x;
      apply_reset();
      rst_n            = 1'b1;
      bus.inst_consume = 1'b1;
      mem_delay        = 3;
      branch_en        = 1'b1;
      branch_addr      = 16'h0005;
      @(negedge clk);
      branch_en = 1'b0;
      fetch_en  = 1'b1;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL disc_req got=%0h want=1", bus.mem_req); end
      checks++; if (bus.mem_addr !== 16'h0005) begin errors++; $display("FAIL disc_req_addr got=%0h want=0005", bus.mem_addr); end
      branch_en   = 1'b1;
      branch_addr = 16'h0040;
      @(negedge clk);
      branch_en = 1'b0;
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL disc_req_held got=%0h want=1", bus.mem_req); end
      checks++; if (bus.mem_addr !== 16'h0005) begin errors++; $display("FAIL disc_addr_held got=%0h want=0005", bus.mem_addr); end
      for (int s = 0; s < 30 && !got_valid; s++) begin
         @(negedge clk);
         if (bus.mem_req !== 1'b1) seen_low = 1'b1;
         else if (seen_low && !got_addr) begin next_addr = bus.mem_addr; got_addr = 1'b1; end
         if (bus.inst_valid === 1'b1) begin
            first_pc = bus.inst_pc; first_inst = bus.inst; got_valid = 1'b1;
         end
      end
      checks++; if (!got_valid) begin errors++; $display("FAIL disc_timeout got=no_valid want=valid"); end
      checks++; if (next_addr !== 16'h0040) begin errors++; $display("FAIL disc_next_req got=%0h want=0040", next_addr); end
      checks++; if (first_pc !== 16'h0040) begin errors++; $display("FAIL disc_first_pc got=%0h want=0040", first_pc); end
      checks++; if (first_inst !== 16'h1040) begin errors++; $display("FAIL disc_first_inst got=%0h want=1040", first_inst); end
   endtask

   task automatic test_branch_ack_consume();
      logic        found = 1'b0;
      logic        got_valid = 1'b0;
      logic [15:0] first_pc = 'x;
      logic [15:0] first_inst = 'x;
      apply_reset();
      rst_n     = 1'b1;
      fetch_en  = 1'b1;
      mem_delay = 2;
      for (int s = 0; s < 40 && !found; s++) begin
         @(negedge clk);
         if (bus.mem_ack === 1'b1 && bus.mem_req === 1'b1 && bus.mem_addr === 16'(DEPTH - 1)) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL bac_timeout got=no_ack want=ack"); end
      checks++; if (bus.inst_valid !== (DEPTH > 1)) begin errors++; $display("FAIL bac_prior_valid got=%0h want=%0h", bus.inst_valid, DEPTH > 1); end
      branch_en        = 1'b1;
      branch_addr      = 16'h0080;
      bus.inst_consume = 1'b1;
      @(negedge clk);
      branch_en = 1'b0;
      checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL bac_flushed got=%0h want=0", bus.inst_valid); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL bac_idle got=%0h want=0", bus.mem_req); end
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL bac_new_req got=%0h want=1", bus.mem_req); end
      checks++; if (bus.mem_addr !== 16'h0080) begin errors++; $display("FAIL bac_new_addr got=%0h want=0080", bus.mem_addr); end
      for (int s = 0; s < 10 && !got_valid; s++) begin
         if (bus.inst_valid === 1'b1) begin
            first_pc = bus.inst_pc; first_inst = bus.inst; got_valid = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      checks++; if (first_pc !== 16'h0080) begin errors++; $display("FAIL bac_first_pc got=%0h want=0080", first_pc); end
      checks++; if (first_inst !== 16'h1080) begin errors++; $display("FAIL bac_first_inst got=%0h want=1080", first_inst); end
   endtask

   task automatic test_wrap();
      logic [15:0] rec_pc [2];
      logic [15:0] rec_inst [2];
      int          n = 0;
      for (int k = 0; k < 2; k++) begin
         rec_pc[k] = 'x; rec_inst[k] = 'x;
      end
      apply_reset();
      rst_n            = 1'b1;
      bus.inst_consume = 1'b1;
      branch_en        = 1'b1;
      branch_addr      = 16'hFFFF;
      @(negedge clk);
      branch_en = 1'b0;
      fetch_en  = 1'b1;
      for (int s = 0; s < 12; s++) begin
         @(negedge clk);
         if (bus.inst_valid === 1'b1 && n < 2) begin
            rec_pc[n] = bus.inst_pc; rec_inst[n] = bus.inst; n++;
         end
      end
      checks++; if (n != 2) begin errors++; $display("FAIL wrap_count got=%0d want=2", n); end
      checks++; if (rec_pc[0] !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc0 got=%0h want=ffff", rec_pc[0]); end
      checks++; if (rec_inst[0] !== 16'h0FFF) begin errors++; $display("FAIL wrap_inst0 got=%0h want=0fff", rec_inst[0]); end
      checks++; if (rec_pc[1] !== 16'h0000) begin errors++; $display("FAIL wrap_pc1 got=%0h want=0000", rec_pc[1]); end
      checks++; if (rec_inst[1] !== 16'h1000) begin errors++; $display("FAIL wrap_inst1 got=%0h want=1000", rec_inst[1]); end
   endtask

   task automatic test_reset_mid_request();
      logic        found = 1'b0;
      logic        got_req = 1'b0;
      logic        got_valid = 1'b0;
      logic [15:0] first_addr = 'x;
      logic [15:0] first_pc = 'x;
      logic [15:0] first_inst = 'x;
      apply_reset();
      rst_n            = 1'b1;
      fetch_en         = 1'b1;
      bus.inst_consume = 1'b1;
      mem_delay        = 3;
      for (int s = 0; s < 60 && !found; s++) begin
         @(negedge clk);
         if (bus.mem_req === 1'b1 && bus.mem_addr === 16'h0002) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL rmid_timeout got=no_req want=req_0002"); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rmid_req got=%0h want=0", bus.mem_req); end
      checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%0h want=0", bus.inst_valid); end
      checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL rmid_addr got=%0h want=0", bus.mem_addr); end
      rst_n = 1'b1;
      for (int s = 0; s < 30 && !got_valid; s++) begin
         @(negedge clk);
         if (bus.mem_req === 1'b1 && !got_req) begin first_addr = bus.mem_addr; got_req = 1'b1; end
         if (bus.inst_valid === 1'b1) begin
            first_pc = bus.inst_pc; first_inst = bus.inst; got_valid = 1'b1;
         end
      end
      checks++; if (first_addr !== 16'h0000) begin errors++; $display("FAIL rmid_restart_addr got=%0h want=0000", first_addr); end
      checks++; if (first_pc !== 16'h0000) begin errors++; $display("FAIL rmid_first_pc got=%0h want=0000", first_pc); end
      checks++; if (first_inst !== 16'h1000) begin errors++; $display("FAIL rmid_first_inst got=%0h want=1000", first_inst); end
   endtask

   initial begin
      rst_n            = 1'b0;
      fetch_en         = 1'b0;
      branch_en        = 1'b0;
      branch_addr      = '0;
      bus.inst_consume = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_branch_discard();
      test_branch_ack_consume();
      test_wrap();
      test_reset_mid_request();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
